// File: rtl/gcn_pkg.sv
// ============================================================================
// Module      : gcn_pkg
// Description : Shared types and default sizes for the GCN classification
//               stage argmax scanner.
//               Contents:
//                 ARGMAX_ROWS    default number of matrix rows (nodes)
//                 ARGMAX_COLS    default number of matrix columns (classes)
//                 ARGMAX_DATA_W  default signed element width
//                 argmax_scan_state_t  row-scanner controller state
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcn_pkg;

  localparam int ARGMAX_ROWS   = 6;
  localparam int ARGMAX_COLS   = 3;
  localparam int ARGMAX_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } argmax_scan_state_t;

endpackage

`default_nettype wire

// File: rtl/argmax_compare_unit.sv
// ============================================================================
// Module      : argmax_compare_unit
// Description : Running max / argmax tracker for one matrix row.
//               Ports:
//                 clk, reset     clock and synchronous active-high reset
//                 valid_i        data_i carries a matrix element this cycle
//                 first_i        element is column 0 (loads unconditionally)
//                 col_i          column index of the element
//                 data_i         signed element value
//                 max_nxt_o      running max including this cycle's element
//                 idx_nxt_o      column of that max
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_compare_unit
  import gcn_pkg::*;
#(
  parameter int DATA_W = ARGMAX_DATA_W,
  parameter int COL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic                     first_i,
  input  logic [COL_W-1:0]         col_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [DATA_W-1:0] max_nxt_o,
  output logic [COL_W-1:0]         idx_nxt_o
);

  logic signed [DATA_W-1:0] max_q, max_d;
  logic [COL_W-1:0]         idx_q, idx_d;

  // Strict greater-than: a tie never moves the index, so the lowest
  // column wins among equal values.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (valid_i && (first_i || (data_i > max_q))) begin
      max_d = data_i;
      idx_d = col_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  // The last element of a row is compared in the same cycle the controller
  // latches the row result, so the next-state values are exported.
  assign max_nxt_o = max_d;
  assign idx_nxt_o = idx_d;

endmodule

`default_nettype wire

// File: rtl/argmax_row_scanner.sv
// ============================================================================
// Module      : argmax_row_scanner
// Description : Scans a ROWS x COLS signed result matrix row by row, one
//               element read per cycle, and reports the argmax of each row.
//               Ports:
//                 clk, reset  clock and synchronous active-high reset
//                 start       scan request, honoured in IDLE/DONE only
//                 rd_en       element read request (1-cycle read latency)
//                 rd_row      read row address
//                 rd_col      read column address
//                 rd_data     signed element, valid 1 cycle after rd_en
//                 res_valid   1-cycle pulse, res_* describe a finished row
//                 res_row     row index of the result
//                 res_idx     argmax column of that row
//                 res_max     max value of that row
//                 busy        scan in progress
//                 done        all rows reported, held until start/reset
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_row_scanner
  import gcn_pkg::*;
#(
  parameter int ROWS   = ARGMAX_ROWS,
  parameter int COLS   = ARGMAX_COLS,
  parameter int DATA_W = ARGMAX_DATA_W,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ROW_W-1:0]         rd_row,
  output logic [COL_W-1:0]         rd_col,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     res_valid,
  output logic [ROW_W-1:0]         res_row,
  output logic [COL_W-1:0]         res_idx,
  output logic signed [DATA_W-1:0] res_max,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  argmax_scan_state_t       state_q;
  logic [ROW_W-1:0]         row_q;
  logic [COL_W-1:0]         col_q;
  logic                     res_valid_q;
  logic [ROW_W-1:0]         res_row_q;
  logic [COL_W-1:0]         res_idx_q;
  logic signed [DATA_W-1:0] res_max_q;

  // Read request qualifiers delayed to line up with rd_data.
  logic                     rd_vld_q;
  logic                     rd_first_q;
  logic [COL_W-1:0]         rd_col_q;

  logic signed [DATA_W-1:0] cmp_max_nxt;
  logic [COL_W-1:0]         cmp_idx_nxt;

  assign rd_en  = (state_q == SCAN);
  assign rd_row = row_q;
  assign rd_col = col_q;
  assign busy   = (state_q == SCAN) || (state_q == DRAIN) || (state_q == WRITE);
  assign done   = (state_q == DONE);

  assign res_valid = res_valid_q;
  assign res_row   = res_row_q;
  assign res_idx   = res_idx_q;
  assign res_max   = res_max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_col_q   <= '0;
    end else begin
      rd_vld_q   <= rd_en;
      rd_first_q <= rd_en && (col_q == '0);
      rd_col_q   <= col_q;
    end
  end

  argmax_compare_unit #(
    .DATA_W (DATA_W),
    .COL_W  (COL_W)
  ) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (rd_vld_q),
    .first_i   (rd_first_q),
    .col_i     (rd_col_q),
    .data_i    (rd_data),
    .max_nxt_o (cmp_max_nxt),
    .idx_nxt_o (cmp_idx_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_idx_q   <= '0;
      res_max_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          res_valid_q <= 1'b0;
          if (start) begin
            state_q <= SCAN;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        SCAN: begin
          // Column counter parks on the last column instead of wrapping.
          if (col_q == LAST_COL) begin
            state_q <= DRAIN;
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        DRAIN: begin
          // Final element of the row is on rd_data now; capture the result
          // including it so res_valid rises together with WRITE.
          state_q     <= WRITE;
          res_valid_q <= 1'b1;
          res_row_q   <= row_q;
          res_idx_q   <= cmp_idx_nxt;
          res_max_q   <= cmp_max_nxt;
        end
        WRITE: begin
          res_valid_q <= 1'b0;
          if (row_q == LAST_ROW) begin
            state_q <= DONE;
          end else begin
            state_q <= SCAN;
            row_q   <= row_q + ROW_W'(1);
            col_q   <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_argmax_row_scanner.sv
// ============================================================================
// Module      : tb_argmax_row_scanner
// Description : Self-checking bench for argmax_row_scanner (6 x 3 x 16-bit)
//               with a 1-cycle-latency memory model and a row-argmax
//               reference computed directly from the matrix contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_argmax_row_scanner;

  localparam int ROWS     = 6;
  localparam int COLS     = 3;
  localparam int DW       = 16;
  localparam int RW       = 3;
  localparam int CW       = 2;
  localparam int ROWLEN   = COLS + 2;
  localparam int LAST_REL = ROWS * ROWLEN + 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 rd_en;
  logic [RW-1:0]        rd_row;
  logic [CW-1:0]        rd_col;
  logic signed [DW-1:0] rd_data;
  logic                 res_valid;
  logic [RW-1:0]        res_row;
  logic [CW-1:0]        res_idx;
  logic signed [DW-1:0] res_max;
  logic                 busy;
  logic                 done;

  logic signed [DW-1:0] mem     [ROWS][COLS];
  int                   exp_idx [ROWS];
  logic signed [DW-1:0] exp_max [ROWS];
  int                   obs_idx [ROWS];
  logic signed [DW-1:0] obs_max [ROWS];

  int n_checks = 0;
  int n_errors = 0;

  argmax_row_scanner #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_idx   (res_idx),
    .res_max   (res_max),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Result memory: data appears one cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (rd_en && (int'(rd_row) < ROWS) && (int'(rd_col) < COLS))
      rd_data <= mem[rd_row][rd_col];
    else
      rd_data <= DW'($urandom);
  end

  // Reference: first column seeds the max, later columns win only if larger.
  function automatic void build_model();
    for (int r = 0; r < ROWS; r++) begin
      exp_max[r] = mem[r][0];
      exp_idx[r] = 0;
      for (int c = 1; c < COLS; c++) begin
        if (mem[r][c] > exp_max[r]) begin
          exp_max[r] = mem[r][c];
          exp_idx[r] = c;
        end
      end
    end
  endfunction

  function automatic void fill_random(input int narrow);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = narrow ? DW'(int'($urandom_range(0, 4)) - 2) : DW'($urandom);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en, res_valid, busy, done} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: rd_en/res_valid/busy/done=%b required 0000",
               {rd_en, res_valid, busy, done});
    end
    n_checks++;
    if (res_row !== '0 || res_idx !== '0 || res_max !== '0) begin
      n_errors++;
      $display("FAIL reset_res: row=%0d idx=%0d max=%0d required 0/0/0",
               res_row, res_idx, res_max);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_hold: busy=%b done=%b rd_en=%b required 0/0/0",
               busy, done, rd_en);
    end
  endtask

  // Starts a scan from IDLE or DONE and checks every cycle against the
  // expected schedule; extra start pulses land at relative cycles pa/pb.
  task automatic test_full_run(input string name, input int pa, input int pb);
    int  n_rd;
    int  n_res;
    int  r;
    int  rem;
    bit  e_busy;
    bit  e_rd;
    bit  e_val;
    n_rd  = 0;
    n_res = 0;
    build_model();
    for (int rel = 0; rel <= LAST_REL; rel++) begin
      @(negedge clk);
      if (rel > 0) begin
        r      = (rel - 1) / ROWLEN;
        rem    = (rel - 1) % ROWLEN;
        e_busy = (rel <= ROWS * ROWLEN);
        e_rd   = e_busy && (rem < COLS);
        e_val  = e_busy && (rem == ROWLEN - 1);
        n_checks++;
        if (busy !== e_busy || done !== !e_busy) begin
          n_errors++;
          $display("FAIL %s busy_done c%0d: busy=%b done=%b required %b/%b",
                   name, rel, busy, done, e_busy, !e_busy);
        end
        n_checks++;
        if (rd_en !== e_rd || res_valid !== e_val) begin
          n_errors++;
          $display("FAIL %s strobes c%0d: rd_en=%b res_valid=%b required %b/%b",
                   name, rel, rd_en, res_valid, e_rd, e_val);
        end
        if (rd_en === 1'b1) n_rd++;
        if (res_valid === 1'b1) n_res++;
        if (e_rd) begin
          n_checks++;
          if (rd_row !== RW'(r) || rd_col !== CW'(rem)) begin
            n_errors++;
            $display("FAIL %s rd_addr c%0d: row=%0d col=%0d required %0d/%0d",
                     name, rel, rd_row, rd_col, r, rem);
          end
        end
        if (e_val) begin
          obs_idx[r] = int'(res_idx);
          obs_max[r] = res_max;
          n_checks++;
          if (res_row !== RW'(r) || res_idx !== CW'(exp_idx[r]) || res_max !== exp_max[r]) begin
            n_errors++;
            $display("FAIL %s result r%0d: row=%0d idx=%0d max=%0d required %0d/%0d/%0d",
                     name, r, res_row, res_idx, res_max, r, exp_idx[r], exp_max[r]);
          end
        end
      end
      start = (rel == 0) || (rel == pa) || (rel == pb);
    end
    start = 1'b0;
    n_checks++;
    if (n_rd != ROWS * COLS || n_res != ROWS) begin
      n_errors++;
      $display("FAIL %s counts: rd_en=%0d res_valid=%0d required %0d/%0d",
               name, n_rd, n_res, ROWS * COLS, ROWS);
    end
  endtask

  task automatic test_directed();
    int lit_idx [4];
    int lit_max [4];
    mem[0][0] = DW'(5);      mem[0][1] = DW'(-2);    mem[0][2] = DW'(9);
    mem[1][0] = DW'(7);      mem[1][1] = DW'(7);     mem[1][2] = DW'(3);
    mem[2][0] = DW'(-8);     mem[2][1] = DW'(-3);    mem[2][2] = DW'(-5);
    mem[3][0] = DW'(-32768); mem[3][1] = DW'(32767); mem[3][2] = DW'(32767);
    mem[4][0] = DW'(-1);     mem[4][1] = DW'(-1);    mem[4][2] = DW'(0);
    mem[5][0] = DW'(100);    mem[5][1] = DW'(-100);  mem[5][2] = DW'(99);
    lit_idx = '{2, 0, 1, 1};
    lit_max = '{9, 7, -3, 32767};
    test_full_run("directed", -1, -1);
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (obs_idx[r] != lit_idx[r] || obs_max[r] !== DW'(lit_max[r])) begin
        n_errors++;
        $display("FAIL directed_lit r%0d: idx=%0d max=%0d required %0d/%0d",
                 r, obs_idx[r], obs_max[r], lit_idx[r], lit_max[r]);
      end
    end
  endtask

  task automatic test_done_restart();
    int                   prev_idx [ROWS];
    logic signed [DW-1:0] prev_max [ROWS];
    for (int r = 0; r < ROWS; r++) begin
      prev_idx[r] = obs_idx[r];
      prev_max[r] = obs_max[r];
    end
    test_full_run("done_restart", -1, -1);
    for (int r = 0; r < ROWS; r++) begin
      n_checks++;
      if (obs_idx[r] != prev_idx[r] || obs_max[r] !== prev_max[r]) begin
        n_errors++;
        $display("FAIL rescan_same r%0d: idx=%0d max=%0d required %0d/%0d",
                 r, obs_idx[r], obs_max[r], prev_idx[r], prev_max[r]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      fill_random(it % 2);
      test_full_run("random", -1, -1);
    end
  endtask

  task automatic test_start_while_busy();
    fill_random(1);
    test_full_run("start_busy", 3, 12);
  endtask

  task automatic test_reset_mid();
    fill_random(0);
    for (int rel = 0; rel <= 8; rel++) begin
      @(negedge clk);
      start = (rel == 0);
    end
    // Reset and start asserted together during cycle 8: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({rd_en, res_valid, busy, done} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_reset_ctrl: rd_en/res_valid/busy/done=%b required 0000",
               {rd_en, res_valid, busy, done});
    end
    n_checks++;
    if (res_row !== '0 || res_idx !== '0 || res_max !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_res: row=%0d idx=%0d max=%0d required 0/0/0",
               res_row, res_idx, res_max);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        n_errors++;
        $display("FAIL post_reset_quiet k%0d: res_valid=%b busy=%b rd_en=%b required 0/0/0",
                 k, res_valid, busy, rd_en);
      end
    end
    test_full_run("after_reset", -1, -1);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    rd_data = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = '0;
    test_reset();
    test_directed();
    test_done_restart();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
